trace_packet_buffer: RTL and testbench
======================================

Name: trace_packet_buffer

Overview:
- Downstream stage of the trace filter.
- Consumes the per-instruction trace stream (pc, instr) together with the filter's drop_instr verdict and discards dropped items.
- Buffers kept items in a FIFO and emits them as fixed-length packets on a valid/ready stream toward the host-transfer logic (DMA/AXI-Stream bridge).
- Keeps kept/dropped/lost statistics for software.

Parameters:
- PC_WIDTH, 64, width of traced program counter.
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PKT_LEN, 8, items per packet; minimum 1; tlast on every PKT_LEN-th item.
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  capture enable; 0 = ignore all input items.
- trace_valid  in  1  retired-instruction item present this cycle.
- pc  in  PC_WIDTH  program counter of item.
- instr  in  32  instruction word of item.
- drop_instr  in  1  filter verdict, aligned with trace_valid in the same cycle.
- flush  in  1  single-cycle pulse; closes the current packet early.
- m_tdata  out  PC_WIDTH+32 (+32 with option)  item, {pc, instr} (timestamp MSBs if enabled).
- m_tvalid  out  1  head entry valid.
- m_tlast  out  1  head entry ends a packet.
- m_tready  in  1  consumer accepts head entry.
- overflow  out  1  sticky: at least one kept item lost since reset/clear.
- clear_stats  in  1  pulse; zeroes counters and overflow.
- kept_cnt, dropped_cnt, lost_cnt  out  CNT_WIDTH each  statistics.

Behaviour:
- Reset (rst_n=0, async):
  - FIFO empty; m_tvalid=0, m_tlast=0, m_tdata=0.
  - overflow=0; all counters 0.
  - Packet position counter 0; flush-pending flag 0.
- Item classification on a rising edge with en=1 and trace_valid=1:
  - drop_instr=1: dropped_cnt++; nothing else changes.
  - drop_instr=0 and FIFO not full: entry written; kept_cnt++.
  - drop_instr=0 and FIFO full: item lost; lost_cnt++; overflow<=1. Full blocks the write even if a pop occurs in the same cycle.
- en=0 or trace_valid=0: no write; counters hold. Output drains normally.
- tlast generation:
  - Written entry's tlast=1 if packet position == PKT_LEN-1, or flush is asserted this cycle, or flush-pending=1.
  - Packet position increments per written entry and resets to 0 after any tlast=1 write. Lost items do not advance position.
  - flush with no write that cycle: flush-pending<=1, cleared by the next written entry.
  - flush while flush-pending is already set: no additional effect.
- Output handshake (first-word fall-through):
  - m_tvalid=1 whenever FIFO is non-empty; m_tdata/m_tlast show the head entry.
  - Pop on m_tvalid & m_tready.
  - Latency: item accepted at edge N is visible on m_tvalid after edge N when the FIFO was empty.
  - Head entry and m_tvalid stay stable while m_tready=0.
- Simultaneous push and pop when not full: both occur; occupancy unchanged.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. Full = MSBs differ and LSBs equal; empty = pointers equal.
- Counters saturate at all-ones; never wrap.
- clear_stats: counters and overflow <=0 next edge. An event in the same cycle is discarded, not counted. FIFO contents untouched.
- Reset mid-packet discards FIFO contents and any pending flush.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Free-running 32-bit cycle counter, reset 0, wraps.
  - Each written entry stores the counter value of its accept cycle.
  - m_tdata = {timestamp, pc, instr}, width PC_WIDTH+64.
- Undefined: no counter; m_tdata = {pc, instr}, width PC_WIDTH+32.

Test Plan:
- Reset, then 10 valid items with drop_instr alternating 0/1 (start 0), m_tready=1 -> 5 items out in order; tlast on none (PKT_LEN=8); kept_cnt=5, dropped_cnt=5, lost_cnt=0.
- 8 kept items, m_tready=1 -> exactly the 8th item has m_tlast=1; the 9th item starts a new packet with position 0.
- 3 kept items, flush pulse on an idle cycle, then 1 kept item -> the 4th item has m_tlast=1; the next 8 items get tlast only on the 8th.
- m_tready=0, 20 kept items (DEPTH=16) -> 16 buffered, lost_cnt=4, overflow=1. Then m_tready=1 -> 16 items drain in order; m_tvalid=0 after the last.
- Push and pop every cycle with FIFO at 15 entries for 100 cycles -> occupancy stays 15, no loss. clear_stats pulse -> all counters 0, overflow=0, data unaffected.
- Assert rst_n=0 asynchronously mid-stream with 5 entries queued -> m_tvalid drops immediately and counters read 0. With TRACE_TIMESTAMP_EN, items accepted on consecutive cycles carry timestamps differing by exactly 1.

Source files
------------

// File: rtl/trace_packet_buffer.sv
// Trace packet buffer: drops filtered items, queues kept items in a FWFT FIFO and frames them
// into PKT_LEN-item packets. Define TRACE_TIMESTAMP_EN to prepend a 32-bit cycle timestamp.
module trace_packet_buffer #(
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PKT_LEN   = 8,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 trace_valid,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [31:0]          instr,
  input  logic                 drop_instr,
  input  logic                 flush,
`ifdef TRACE_TIMESTAMP_EN
  output logic [PC_WIDTH+63:0] m_tdata,
`else
  output logic [PC_WIDTH+31:0] m_tdata,
`endif
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready,
  output logic                 overflow,
  input  logic                 clear_stats,
  output logic [CNT_WIDTH-1:0] kept_cnt,
  output logic [CNT_WIDTH-1:0] dropped_cnt,
  output logic [CNT_WIDTH-1:0] lost_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned DW = PC_WIDTH + 64;
`else
  localparam int unsigned DW = PC_WIDTH + 32;
`endif

  logic [DW-1:0]        data_mem_q [DEPTH];
  logic [DEPTH-1:0]     last_mem_q;
  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [CNT_WIDTH-1:0] kept_q, dropped_q, lost_q;
  logic                 overflow_q;
  logic [DW-1:0]        wr_data;

  logic empty, full, item, keep_ev, drop_ev, push, lost_ev, pop, wr_last;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign item    = en & trace_valid;
  assign keep_ev = item & ~drop_instr;
  assign drop_ev = item & drop_instr;
  // Full blocks the write even when the head is popped in the same cycle.
  assign push    = keep_ev & ~full;
  assign lost_ev = keep_ev & full;
  assign pop     = ~empty & m_tready;
  assign wr_last = (pos_q == PW'(PKT_LEN - 1)) | flush | flush_pend_q;

`ifdef TRACE_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign wr_data = {ts_q, pc, instr};
`else
  assign wr_data = {pc, instr};
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    pos_d        = pos_q;
    flush_pend_d = flush_pend_q;
    if (push) begin
      flush_pend_d = 1'b0;
      pos_d        = wr_last ? '0 : pos_q + PW'(1);
    end else if (flush) begin
      flush_pend_d = 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      last_mem_q[wr_ptr_q[AW-1:0]] <= wr_last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pos_q        <= '0;
      flush_pend_q <= 1'b0;
      kept_q       <= '0;
      dropped_q    <= '0;
      lost_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      pos_q        <= pos_d;
      flush_pend_q <= flush_pend_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
      end
      if (clear_stats) begin
        kept_q     <= '0;
        dropped_q  <= '0;
        lost_q     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push) begin
          kept_q <= sat_inc(kept_q);
        end
        if (drop_ev) begin
          dropped_q <= sat_inc(dropped_q);
        end
        if (lost_ev) begin
          lost_q     <= sat_inc(lost_q);
          overflow_q <= 1'b1;
        end
      end
    end
  end

  assign m_tvalid    = ~empty;
  assign m_tdata     = empty ? '0 : data_mem_q[rd_ptr_q[AW-1:0]];
  assign m_tlast     = ~empty & last_mem_q[rd_ptr_q[AW-1:0]];
  assign overflow    = overflow_q;
  assign kept_cnt    = kept_q;
  assign dropped_cnt = dropped_q;
  assign lost_cnt    = lost_q;

endmodule

// File: tb/tb_trace_packet_buffer.sv
// Scoreboard bench for trace_packet_buffer: stimulus queues expected {tlast, pc, instr}; a
// negedge monitor pops and compares on every handshake.
module tb_trace_packet_buffer;

  localparam int unsigned PCW = 64;
`ifdef TRACE_TIMESTAMP_EN
  localparam int unsigned TDW = PCW + 64;
`else
  localparam int unsigned TDW = PCW + 32;
`endif

  typedef logic [PCW+32:0] exp_t;

  logic           clk, rst_n, en, trace_valid, drop_instr, flush;
  logic [PCW-1:0] pc;
  logic [31:0]    instr;
  logic [TDW-1:0] m_tdata;
  logic           m_tvalid, m_tlast, m_tready, overflow, clear_stats;
  logic [31:0]    kept_cnt, dropped_cnt, lost_cnt;

  int   tests;
  int   failed;
  int   id;
  int   first_id;
  int   j;
  exp_t exp_q[$];
  logic [31:0] ts_seen[$];

  trace_packet_buffer #(
    .PC_WIDTH (PCW),
    .DEPTH    (16),
    .PKT_LEN  (8),
    .CNT_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .trace_valid(trace_valid),
    .pc         (pc),
    .instr      (instr),
    .drop_instr (drop_instr),
    .flush      (flush),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .overflow   (overflow),
    .clear_stats(clear_stats),
    .kept_cnt   (kept_cnt),
    .dropped_cnt(dropped_cnt),
    .lost_cnt   (lost_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [PCW+31:0] item_data(input int k);
    logic [PCW-1:0] p;
    logic [31:0]    w;
    p = 64'h1000 + 64'(k) * 64'd4;
    w = 32'hA500_0000 + 32'(k);
    return {p, w};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic drop, input logic flsh, input logic store, input logic last);
    logic [PCW+31:0] d;
    d           = item_data(id);
    trace_valid = 1'b1;
    drop_instr  = drop;
    flush       = flsh;
    pc          = d[PCW+31:32];
    instr       = d[31:0];
    if (store) exp_q.push_back({last, d});
    id++;
    @(posedge clk);
    #1;
    trace_valid = 1'b0;
    drop_instr  = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic idle_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    trace_valid = 1'b0;
    flush       = 1'b0;
    clear_stats = 1'b0;
    rst_n       = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 128'(exp_q.size()), 128'(0));
    check("drain_tvalid", 128'(m_tvalid), 128'(0));
  endtask

  task automatic check_stats(input string name, input int k, input int d, input int l,
                             input logic ovf);
    check({name, "_kept"}, 128'(kept_cnt), 128'(k));
    check({name, "_dropped"}, 128'(dropped_cnt), 128'(d));
    check({name, "_lost"}, 128'(lost_cnt), 128'(l));
    check({name, "_overflow"}, 128'(overflow), 128'(ovf));
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst_n && m_tvalid && m_tready) begin
      tests++;
      got = {m_tlast, m_tdata[PCW+31:0]};
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_item: got %0h, required no item", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failed++;
          $display("FAIL item: got %0h, required %0h", got, e);
        end
      end
`ifdef TRACE_TIMESTAMP_EN
      ts_seen.push_back(m_tdata[PCW+63:PCW+32]);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; en = 1'b1; trace_valid = 1'b0; drop_instr = 1'b0;
    flush = 1'b0; pc = '0; instr = '0; m_tready = 1'b0; clear_stats = 1'b0;
    tests = 0; failed = 0; id = 0;

    // Reset state and alternating drop verdicts.
    do_reset();
    check("rst_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_tlast", 128'(m_tlast), 128'(0));
    check("rst_tdata", 128'(m_tdata), 128'(0));
    check_stats("rst", 0, 0, 0, 1'b0);
    m_tready = 1'b1;
    send(1'b0, 1'b0, 1'b1, 1'b0);
    check("latency_tvalid", 128'(m_tvalid), 128'(1));
    for (int i = 1; i < 10; i++) send(1'(i % 2), 1'b0, ~1'(i % 2), 1'b0);
    drain(20);
    check_stats("alt", 5, 5, 0, 1'b0);

    // Two full packets back to back.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) send(1'b0, 1'b0, 1'b1, (i == 7) || (i == 15));
    drain(30);

    // Flush on idle cycles (repeated), then in the same cycle as a write.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b1, 1'b0);
    idle_flush();
    idle_flush();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b0, 1'b1, i == 7);
    send(1'b0, 1'b1, 1'b1, 1'b1);
    send(1'b0, 1'b0, 1'b1, 1'b0);
    drain(30);
    check_stats("flush", 14, 0, 0, 1'b0);

    // Overflow with a stalled consumer; full blocks a write despite a same-cycle pop.
    do_reset();
    m_tready = 1'b0;
    first_id = id;
    for (int i = 0; i < 20; i++) send(1'b0, 1'b0, i < 16, (i == 7) || (i == 15));
    check("stall_head", 128'(m_tdata[PCW+31:0]), 128'(item_data(first_id)));
    check("stall_tlast", 128'(m_tlast), 128'(0));
    check_stats("ovf", 16, 0, 4, 1'b1);
    m_tready = 1'b1;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    check("full_pop_lost", 128'(lost_cnt), 128'(5));
    drain(40);

    // Steady push/pop at 15 entries, then clear_stats.
    do_reset();
    m_tready = 1'b0;
    j = 0;
    for (int i = 0; i < 15; i++) begin
      send(1'b0, 1'b0, 1'b1, (j % 8) == 7);
      j++;
    end
    m_tready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      send(1'b0, 1'b0, 1'b1, (j % 8) == 7);
      j++;
    end
    m_tready = 1'b0;
    check_stats("steady", 115, 0, 0, 1'b0);
    clear_stats = 1'b1;
    send(1'b1, 1'b0, 1'b0, 1'b0);
    clear_stats = 1'b0;
    check_stats("clr", 0, 0, 0, 1'b0);
    send(1'b0, 1'b0, 1'b1, (j % 8) == 7);
    j++;
    send(1'b0, 1'b0, 1'b0, 1'b0);
    check_stats("occ15", 1, 0, 1, 1'b1);
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    check_stats("clr2", 0, 0, 0, 1'b0);
    m_tready = 1'b1;
    drain(40);

    // Asynchronous reset with entries queued and a flush pending.
    do_reset();
    m_tready = 1'b0;
    idle_flush();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0, 1'b1, i == 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_tvalid", 128'(m_tvalid), 128'(0));
    check("arst_tdata", 128'(m_tdata), 128'(0));
    check_stats("arst", 0, 0, 0, 1'b0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    send(1'b0, 1'b0, 1'b1, 1'b0);
    drain(10);

`ifdef TRACE_TIMESTAMP_EN
    do_reset();
    m_tready = 1'b1;
    ts_seen.delete();
    send(1'b0, 1'b0, 1'b1, 1'b0);
    send(1'b0, 1'b0, 1'b1, 1'b0);
    drain(10);
    check("ts_count", 128'(ts_seen.size()), 128'(2));
    if (ts_seen.size() == 2) check("ts_delta", 128'(ts_seen[1] - ts_seen[0]), 128'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
